// File: rtl/hash_engine_model_if.sv
// rtl/hash_engine_model_if.sv - command/digest bundle between a block-buffer controller and the hash core
// master: controller side, drives init_i/next_i/final_i, block_in_i, data_length_i
// slave : hash core side, drives hash_ready_o, digest_valid_o, digest_o, block_count_o, error_o
interface hash_engine_model_if #(
   parameter int BLOCK_WIDTH   = 512,
   parameter int DIGEST_LENGTH = 88,
   parameter int COUNT_WIDTH   = 64
);
   logic                     init_i;
   logic                     next_i;
   logic                     final_i;
   logic [BLOCK_WIDTH-1:0]   block_in_i;
   logic [COUNT_WIDTH-1:0]   data_length_i;
   logic                     hash_ready_o;
   logic                     digest_valid_o;
   logic [DIGEST_LENGTH-1:0] digest_o;
   logic [COUNT_WIDTH-1:0]   block_count_o;
   logic                     error_o;

   modport master (
      output init_i, next_i, final_i, block_in_i, data_length_i,
      input  hash_ready_o, digest_valid_o, digest_o, block_count_o, error_o
   );

   modport slave (
      input  init_i, next_i, final_i, block_in_i, data_length_i,
      output hash_ready_o, digest_valid_o, digest_o, block_count_o, error_o
   );
endinterface

// File: rtl/hash_engine_model.sv
// rtl/hash_engine_model.sv - cycle-accurate stand-in for a BLAKE2-class hash core with folded digest
// clk     : rising-edge clock
// reset_n : asynchronous active-low reset
// bus     : hash_engine_model_if.slave (init/next/final commands in, ready/digest/count/error out)
// HASH_ERR_STICKY_EN : when defined, error_o holds until reset or an accepted init
module hash_engine_model #(
   parameter int BLOCK_WIDTH   = 512,
   parameter int STATE_WIDTH   = 256,
   parameter int DIGEST_LENGTH = 88,
   parameter int COUNT_WIDTH   = 64,
   parameter int LATENCY       = 10
) (
   input  logic                clk,
   input  logic                reset_n,
   hash_engine_model_if.slave  bus
);
   localparam int NSLICE = BLOCK_WIDTH / STATE_WIDTH;
   localparam int CNT_W  = $clog2(LATENCY + 1);
   localparam logic [STATE_WIDTH-1:0] IV = {(STATE_WIDTH / 32){32'h6A09E667}};

   typedef enum logic [1:0] {IDLE, OPEN, BUSY} fsm_t;

   fsm_t                     fsm_q;
   logic                     is_final_q;
   logic [CNT_W-1:0]         busy_cnt_q;
   logic [STATE_WIDTH-1:0]   state_q, state_d;
   logic [COUNT_WIDTH-1:0]   block_count_q, block_count_d;
   logic                     hash_ready_q;
   logic                     digest_valid_q;
   logic [DIGEST_LENGTH-1:0] digest_q;
   logic                     error_q;

   logic                     cmd_any, cmd_multi, violation, accept;
   logic [STATE_WIDTH-1:0]   fold, base;

   assign cmd_any   = bus.init_i | bus.next_i | bus.final_i;
   assign cmd_multi = (bus.init_i & bus.next_i) | (bus.init_i & bus.final_i) | (bus.next_i & bus.final_i);
   // next/final need an open message; only init may start from IDLE
   assign violation = cmd_any & (~hash_ready_q | cmd_multi | ((fsm_q == IDLE) & ~bus.init_i));
   assign accept    = cmd_any & ~violation;

   always_comb begin
      fold = '0;
      for (int k = 0; k < NSLICE; k++) begin
         fold = fold ^ bus.block_in_i[k*STATE_WIDTH +: STATE_WIDTH];
      end
      base          = bus.init_i ? IV : state_q;
      state_d       = {base[STATE_WIDTH-2:0], base[STATE_WIDTH-1]} ^ fold;
      block_count_d = COUNT_WIDTH'(1);
      if (!bus.init_i) begin
         state_d       = state_d ^ STATE_WIDTH'(block_count_q);
         block_count_d = block_count_q + COUNT_WIDTH'(1);
      end
      if (bus.final_i) begin
         state_d = state_d ^ STATE_WIDTH'(bus.data_length_i);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q          <= IDLE;
         is_final_q     <= 1'b0;
         busy_cnt_q     <= '0;
         state_q        <= '0;
         block_count_q  <= '0;
         hash_ready_q   <= 1'b1;
         digest_valid_q <= 1'b0;
         digest_q       <= '0;
         error_q        <= 1'b0;
      end else begin
`ifdef HASH_ERR_STICKY_EN
         if (accept && bus.init_i) begin
            error_q <= 1'b0;
         end else if (violation) begin
            error_q <= 1'b1;
         end
`else
         error_q <= violation;
`endif
         case (fsm_q)
            IDLE, OPEN: begin
               if (accept) begin
                  state_q       <= state_d;
                  block_count_q <= block_count_d;
                  is_final_q    <= bus.final_i;
                  busy_cnt_q    <= CNT_W'(LATENCY - 1);
                  hash_ready_q  <= 1'b0;
                  fsm_q         <= BUSY;
                  if (bus.init_i) begin
                     digest_valid_q <= 1'b0;
                  end
               end
            end
            BUSY: begin
               // the state is already updated; the count only models core latency
               if (busy_cnt_q == '0) begin
                  hash_ready_q <= 1'b1;
                  if (is_final_q) begin
                     digest_q       <= state_q[DIGEST_LENGTH-1:0];
                     digest_valid_q <= 1'b1;
                     fsm_q          <= IDLE;
                  end else begin
                     fsm_q <= OPEN;
                  end
               end else begin
                  busy_cnt_q <= busy_cnt_q - CNT_W'(1);
               end
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

   assign bus.hash_ready_o   = hash_ready_q;
   assign bus.digest_valid_o = digest_valid_q;
   assign bus.digest_o       = digest_q;
   assign bus.block_count_o  = block_count_q;
   assign bus.error_o        = error_q;
endmodule

// File: tb/tb_hash_engine_model.sv
// tb/tb_hash_engine_model.sv - scoreboard bench for hash_engine_model
module tb_hash_engine_model;
   localparam int BW  = 512;
   localparam int SW  = 256;
   localparam int DL  = 88;
   localparam int CW  = 64;
   localparam int LAT = 10;
   localparam logic [DL-1:0] D0 = 88'h27999DA827999DA827999C;
   localparam logic [SW-1:0] IV = {(SW / 32){32'h6A09E667}};
`ifdef HASH_ERR_STICKY_EN
   localparam logic STICKY = 1'b1;
`else
   localparam logic STICKY = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   hash_engine_model_if #(.BLOCK_WIDTH(BW), .DIGEST_LENGTH(DL), .COUNT_WIDTH(CW)) bus ();

   hash_engine_model #(
      .BLOCK_WIDTH(BW), .STATE_WIDTH(SW), .DIGEST_LENGTH(DL), .COUNT_WIDTH(CW), .LATENCY(LAT)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [DL-1:0] exp_q[$];
   logic [SW-1:0] m_state;
   logic [CW-1:0] m_cnt;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [SW-1:0] model_absorb(input logic [SW-1:0] base, input logic [BW-1:0] blk,
                                                  input logic [CW-1:0] idx, input logic [CW-1:0] len);
      logic [SW-1:0] f;
      f = '0;
      for (int k = 0; k < BW / SW; k++) f = f ^ blk[k*SW +: SW];
      return {base[SW-2:0], base[SW-1]} ^ f ^ SW'(idx) ^ SW'(len);
   endfunction

   function automatic logic [BW-1:0] rand_blk();
      logic [BW-1:0] b;
      for (int k = 0; k < BW / 32; k++) b[k*32 +: 32] = $urandom;
      return b;
   endfunction

   // presents a command for exactly one rising edge; returns 1 ns after that edge
   task automatic drive(input logic i, input logic n, input logic f,
                        input logic [BW-1:0] blk, input logic [CW-1:0] len);
      @(negedge clk);
      bus.init_i = i; bus.next_i = n; bus.final_i = f;
      bus.block_in_i = blk; bus.data_length_i = len;
      @(posedge clk); #1;
      bus.init_i = 1'b0; bus.next_i = 1'b0; bus.final_i = 1'b0;
   endtask

   task automatic wait_ready(input string tag, input int exp_cycles);
      int c = 0;
      while (!bus.hash_ready_o && c < 200) begin
         @(posedge clk); #1; c++;
      end
      check(tag, c, exp_cycles);
   endtask

   task automatic wait_digest(input string tag);
      int c = 0;
      while (!bus.digest_valid_o && c < 200) begin
         @(posedge clk); #1; c++;
      end
      check({tag, "_lat"}, c, LAT);
      check({tag, "_sb"}, exp_q.size(), 1);
      if (exp_q.size() > 0) check({tag, "_digest"}, bus.digest_o, exp_q.pop_front());
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", bus.hash_ready_o, 1);
      check("rst_dvalid", bus.digest_valid_o, 0);
      check("rst_digest", bus.digest_o, 0);
      check("rst_count", bus.block_count_o, 0);
      check("rst_error", bus.error_o, 0);
      @(negedge clk) reset_n = 1'b1;
   endtask

   task automatic do_init(input logic [BW-1:0] blk);
      drive(1, 0, 0, blk, '0);
      m_state = model_absorb(IV, blk, '0, '0);
      m_cnt = 1;
      check("init_busy", bus.hash_ready_o, 0);
      check("init_dvalid", bus.digest_valid_o, 0);
      check("init_error", bus.error_o, 0);
      check("init_count", bus.block_count_o, m_cnt);
      wait_ready("init_lat", LAT);
   endtask

   task automatic do_next(input logic [BW-1:0] blk);
      drive(0, 1, 0, blk, '0);
      m_state = model_absorb(m_state, blk, m_cnt, '0);
      m_cnt++;
      check("next_count", bus.block_count_o, m_cnt);
      wait_ready("next_lat", LAT);
   endtask

   task automatic do_final(input logic [BW-1:0] blk, input logic [CW-1:0] len);
      drive(0, 0, 1, blk, len);
      m_state = model_absorb(m_state, blk, m_cnt, len);
      m_cnt++;
      exp_q.push_back(m_state[DL-1:0]);
      wait_digest("final");
      check("final_count", bus.block_count_o, m_cnt);
      check("final_ready", bus.hash_ready_o, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int hi;
      bus.init_i = 1'b0; bus.next_i = 1'b0; bus.final_i = 1'b0;
      bus.block_in_i = '0; bus.data_length_i = '0;

      do_reset();

      // known-answer message
      do_init('0);
      do_final('0, '0);
      check("kat_digest", bus.digest_o, D0);
      repeat (5) @(negedge clk);
      check("kat_hold", bus.digest_valid_o, 1);

      // new init drops digest_valid; multi-block random message
      do_init(rand_blk());
      do_next(rand_blk());
      do_final(rand_blk(), CW'($urandom));

      // next one cycle after init acceptance is rejected
      drive(1, 0, 0, '0, '0);
      m_state = model_absorb(IV, '0, '0, '0);
      m_cnt = 1;
      drive(0, 1, 0, rand_blk(), '0);
      check("busy_err", bus.error_o, 1);
      check("busy_count", bus.block_count_o, 1);
      @(posedge clk); #1;
      check("busy_err_after", bus.error_o, STICKY);
      wait_ready("busy_lat", LAT - 2);
      do_final('0, '0);
      check("busy_digest", bus.digest_o, D0);

      // next/final from IDLE
      do_reset();
      drive(0, 1, 0, rand_blk(), '0);
      check("idle_next_err", bus.error_o, 1);
      check("idle_next_ready", bus.hash_ready_o, 1);
      check("idle_next_dvalid", bus.digest_valid_o, 0);
      drive(0, 0, 1, rand_blk(), 5);
      check("idle_final_err", bus.error_o, 1);
      check("idle_final_ready", bus.hash_ready_o, 1);
      check("idle_final_count", bus.block_count_o, 0);
      @(posedge clk); #1;
      check("idle_err_after", bus.error_o, STICKY);
      repeat (20) @(posedge clk);
      #1;
      check("idle_err_20", bus.error_o, STICKY);

      // two commands at once
      do_reset();
      drive(1, 0, 1, rand_blk(), 3);
      check("multi_err", bus.error_o, 1);
      check("multi_ready", bus.hash_ready_o, 1);
      check("multi_count", bus.block_count_o, 0);
      do_init('0);
      do_final('0, '0);
      check("multi_digest", bus.digest_o, D0);

      // reset in the middle of a final's busy window
      do_init(rand_blk());
      drive(0, 0, 1, rand_blk(), 7);
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort_ready", bus.hash_ready_o, 1);
      check("abort_dvalid", bus.digest_valid_o, 0);
      check("abort_digest", bus.digest_o, 0);
      check("abort_count", bus.block_count_o, 0);
      check("abort_error", bus.error_o, 0);
      @(negedge clk) reset_n = 1'b1;
      hi = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.digest_valid_o) hi++;
      end
      check("abort_no_digest", hi, 0);

      // random messages of varying length
      for (int m = 0; m < 3; m++) begin
         do_init(rand_blk());
         for (int b = 0; b < m; b++) do_next(rand_blk());
         do_final(rand_blk(), CW'({$urandom, $urandom}));
      end

      check("sb_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
